// File: rtl/fsk_tx_scheduler.sv
// -----------------------------------------------------------------------------
// fsk_tx_scheduler
//
// Transmit sequencer between the Hamming encoder and the FSK tone generator.
// Codewords are buffered in a small FIFO. Each one is optionally prefixed with
// a sync word and sent LSB first, one bit per BIT_CYCLES clk2 periods. Every
// frame is followed by an idle gap of GAP_BITS bit periods.
//
// Configuration macro: FSK_SCHED_PREAMBLE_EN
//   defined   - every frame starts with SYNC_WORD (SYNC_LEN bits, LSB first)
//   undefined - frames carry only the CW_WIDTH data bits; SYNC_* are ignored
//
// Ports:
//   clk2        in   bit-timing clock shared with the FSK generator
//   reset_n     in   asynchronous active-low reset (flushes FIFO, FSM to IDLE)
//   tx_enable   in   allows new frames to start
//   cw_data     in   codeword from the Hamming encoder
//   cw_valid    in   cw_data is valid
//   cw_ready    out  FIFO can accept a codeword
//   tx_bit      out  bit to the FSK generator (1 = f1, 0 = f2)
//   tx_active   out  high while a sync or data bit is on tx_bit
//   bit_strobe  out  one-cycle pulse on the first cycle of each transmitted bit
//   frame_done  out  one-cycle pulse after the last data bit of a frame
//   fifo_level  out  number of stored codewords
// -----------------------------------------------------------------------------
module fsk_tx_scheduler #(
  parameter int                  BIT_CYCLES = 16,
  parameter int                  CW_WIDTH   = 14,
  parameter int                  FIFO_DEPTH = 4,
  parameter int                  SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'hA5,
  parameter int                  GAP_BITS   = 2
) (
  input  logic                          clk2,
  input  logic                          reset_n,
  input  logic                          tx_enable,
  input  logic [CW_WIDTH-1:0]           cw_data,
  input  logic                          cw_valid,
  output logic                          cw_ready,
  output logic                          tx_bit,
  output logic                          tx_active,
  output logic                          bit_strobe,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam int TMR_W      = $clog2(BIT_CYCLES);
  localparam int MAX_BITS_A = (SYNC_LEN > CW_WIDTH) ? SYNC_LEN : CW_WIDTH;
  localparam int MAX_BITS   = (GAP_BITS > MAX_BITS_A) ? GAP_BITS : MAX_BITS_A;
  localparam int BCNT_W     = $clog2(MAX_BITS + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(BIT_CYCLES - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(CW_WIDTH - 1);
  localparam logic [BCNT_W-1:0] GAP_LAST  = BCNT_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

`ifdef FSK_SCHED_PREAMBLE_EN
  localparam int FRAME_W = SYNC_LEN + CW_WIDTH;
  localparam logic [BCNT_W-1:0] SYNC_LAST = BCNT_W'(SYNC_LEN - 1);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;
  localparam state_t FIRST_ST = ST_SYNC;
`else
  localparam int FRAME_W = CW_WIDTH;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;
  localparam state_t FIRST_ST = ST_DATA;
  // The sync pattern has no use without the preamble; fold it away quietly.
  logic unused_sync_s;
  assign unused_sync_s = ^SYNC_WORD;
`endif

  // FIFO storage and bookkeeping
  logic [CW_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [LVL_W-1:0]    count_r;
  logic                push_s;
  logic                pop_s;

  // Frame sequencing
  state_t              state_r;
  state_t              state_nx;
  logic [TMR_W-1:0]    timer_r;
  logic [BCNT_W-1:0]   bit_cnt_r;
  logic [FRAME_W-1:0]  shift_r;
  logic                wrap_s;
  logic                start_ok_s;
  logic                data_last_s;
  logic                active_s;
  logic                done_pend_r;

  // Ready depends only on the registered count, so a pop never frees a slot
  // within the same cycle.
  assign cw_ready    = (count_r != LVL_W'(FIFO_DEPTH));
  assign push_s      = cw_valid && cw_ready;
  assign fifo_level  = count_r;

  assign wrap_s      = (timer_r == TMR_LAST);
  assign start_ok_s  = tx_enable && (count_r != {LVL_W{1'b0}});
  assign data_last_s = wrap_s && (bit_cnt_r == DATA_LAST);

`ifdef FSK_SCHED_PREAMBLE_EN
  assign active_s = (state_r == ST_SYNC) || (state_r == ST_DATA);
`else
  assign active_s = (state_r == ST_DATA);
`endif

  // FIFO data array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk2) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cw_data;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next-state decode; a pop happens only on the cycle a frame is launched.
  always_comb begin
    state_nx = state_r;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          pop_s    = 1'b1;
          state_nx = FIRST_ST;
        end else begin
          state_nx = ST_IDLE;
        end
      end
`ifdef FSK_SCHED_PREAMBLE_EN
      ST_SYNC: begin
        if (wrap_s && (bit_cnt_r == SYNC_LAST)) begin
          state_nx = ST_DATA;
        end else begin
          state_nx = ST_SYNC;
        end
      end
`endif
      ST_DATA: begin
        if (data_last_s) begin
          if (GAP_BITS == 0) begin
            // No gap: the last data cycle doubles as the relaunch point.
            if (start_ok_s) begin
              pop_s    = 1'b1;
              state_nx = FIRST_ST;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            state_nx = ST_GAP;
          end
        end else begin
          state_nx = ST_DATA;
        end
      end
      ST_GAP: begin
        if (wrap_s && (bit_cnt_r == GAP_LAST)) begin
          if (start_ok_s) begin
            pop_s    = 1'b1;
            state_nx = FIRST_ST;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          state_nx = ST_GAP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register, bit timer, per-state bit counter and frame shift register.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TMR_W{1'b0}};
      bit_cnt_r <= {BCNT_W{1'b0}};
      shift_r   <= {FRAME_W{1'b0}};
    end else begin
      state_r <= state_nx;

      if (pop_s || (state_r == ST_IDLE)) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (wrap_s) begin
        timer_r <= {TMR_W{1'b0}};
      end else begin
        timer_r <= timer_r + TMR_W'(1);
      end

      // Counts bits within the current state; restarts on every state change
      // and on a back-to-back relaunch that stays in the same state.
      if (pop_s || (state_nx != state_r)) begin
        bit_cnt_r <= {BCNT_W{1'b0}};
      end else if (wrap_s) begin
        bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      if (pop_s) begin
`ifdef FSK_SCHED_PREAMBLE_EN
        shift_r <= {mem_r[rd_ptr_r], SYNC_WORD};
`else
        shift_r <= mem_r[rd_ptr_r];
`endif
      end else if (active_s && wrap_s) begin
        shift_r <= {1'b0, shift_r[FRAME_W-1:1]};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Registered outputs: one cycle behind the FSM, so frame_done is delayed a
  // second cycle to land on the first idle output cycle after the data bits.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      tx_active   <= 1'b0;
      tx_bit      <= 1'b0;
      bit_strobe  <= 1'b0;
      done_pend_r <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      tx_active   <= active_s;
      tx_bit      <= active_s ? shift_r[0] : 1'b0;
      bit_strobe  <= active_s && (timer_r == {TMR_W{1'b0}});
      done_pend_r <= (state_r == ST_DATA) && data_last_s;
      frame_done  <= done_pend_r;
    end
  end

endmodule
